// File: rtl/qpram_wr_drain.sv
// qpram_wr_drain: buffered write front end for a 64x1 quad-port LUTRAM with read forwarding
module qpram_wr_drain #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 1,
    parameter int DEPTH      = 4,
    parameter int NUM_RD     = 3
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         drain_en,
    output logic                         ram_we,
    output logic [ADDR_WIDTH-1:0]        ram_aw,
    output logic [DATA_WIDTH-1:0]        ram_di,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    input  logic [NUM_RD*DATA_WIDTH-1:0] rd_raw,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [$clog2(DEPTH):0]       occupancy,
    output logic                         idle
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [PW:0]           count_q, count_d;
    logic [DEPTH-1:0]      vld_q, vld_d;
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic                  push;

    assign wr_ready  = count_q != PW'(0) + (PW+1)'(DEPTH) ? 1'b1 : 1'b0;
    assign idle      = count_q == '0;
    assign occupancy = count_q;
    assign push      = wr_valid && wr_ready;
    assign ram_we    = !idle && drain_en;
    assign ram_aw    = addr_q[head_q];
    assign ram_di    = data_q[head_q];

    // Next-state for queue pointers, count and valid bits; push and pop never hit the same slot.
    always_comb begin
        head_d  = ram_we ? head_q + 1'b1 : head_q;
        tail_d  = push ? tail_q + 1'b1 : tail_q;
        count_d = count_q + (PW+1)'(push) - (PW+1)'(ram_we);
        vld_d   = vld_q;
        if (push) vld_d[tail_q] = 1'b1;
        if (ram_we) vld_d[head_q] = 1'b0;
    end

    // Control state; reset discards everything queued.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            vld_q   <= vld_d;
        end
    end

    // Payload storage is qualified by the valid bits, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            addr_q[tail_q] <= wr_addr;
            data_q[tail_q] <= wr_data;
        end
    end

    // Scan oldest to youngest so the youngest matching pending write overrides RAM data.
    always_comb begin
        rd_data = rd_raw;
        for (int i = 0; i < NUM_RD; i++)
            for (int j = 0; j < DEPTH; j++)
                if (vld_q[head_q + PW'(j)] && addr_q[head_q + PW'(j)] == rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH])
                    rd_data[i*DATA_WIDTH +: DATA_WIDTH] = data_q[head_q + PW'(j)];
    end
endmodule

// File: tb/tb_qpram_wr_drain.sv
// tb_qpram_wr_drain: directed scoreboard bench for the LUTRAM write drain queue
module tb_qpram_wr_drain;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [5:0]  wr_addr = '0;
    logic        wr_data = 1'b0;
    logic        drain_en = 1'b0;
    logic        ram_we;
    logic [5:0]  ram_aw;
    logic        ram_di;
    logic [17:0] rd_addr = {3{6'd63}};
    logic [2:0]  rd_raw = '0;
    logic [2:0]  rd_data;
    logic [2:0]  occupancy;
    logic        idle;

    int errs = 0;
    int checks = 0;
    logic [6:0] sb [$];

    qpram_wr_drain dut (
        .CLK(CLK), .RST(RST), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .drain_en(drain_en),
        .ram_we(ram_we), .ram_aw(ram_aw), .ram_di(ram_di),
        .rd_addr(rd_addr), .rd_raw(rd_raw), .rd_data(rd_data),
        .occupancy(occupancy), .idle(idle)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        logic acc, pop;
        logic [6:0] e;
        #1;
        acc = sb.size() < 4;
        pop = sb.size() != 0 && drain_en;
        chk("wr_ready", wr_ready, acc);
        chk("occupancy", occupancy, sb.size());
        chk("ram_we", ram_we, pop);
        if (ram_we) begin
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("ram_aw_di", {ram_aw, ram_di}, e);
            end
        end
        if (wr_valid && acc) sb.push_back({wr_addr, wr_data});
        @(posedge CLK);
        #1;
    endtask

    task automatic put(input logic [5:0] a, input logic d);
        wr_valid = 1'b1;
        wr_addr = a;
        wr_data = d;
        cyc();
        wr_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_idle", idle, 1);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_ram_we", ram_we, 0);
        // single write, no pass-through, one-cycle latency
        drain_en = 1'b1;
        wr_valid = 1'b1; wr_addr = 6'd5; wr_data = 1'b1;
        #1;
        chk("no_passthru", ram_we, 0);
        cyc();
        wr_valid = 1'b0;
        #1;
        chk("t1_we", ram_we, 1);
        chk("t1_aw", ram_aw, 5);
        chk("t1_di", ram_di, 1);
        cyc();
        chk("t1_idle", idle, 1);
        chk("t1_occ", occupancy, 0);
        // fill under stall, reject fifth, drain in order
        drain_en = 1'b0;
        for (int k = 1; k <= 4; k++) put(6'(k), 1'b1);
        chk("full_ready", wr_ready, 0);
        chk("full_occ", occupancy, 4);
        put(6'd6, 1'b1);
        chk("full_occ_hold", occupancy, 4);
        drain_en = 1'b1;
        repeat (4) cyc();
        chk("drain_idle", idle, 1);
        // duplicate address: youngest wins
        drain_en = 1'b0;
        put(6'd9, 1'b1);
        put(6'd9, 1'b0);
        rd_addr = {6'd63, 6'd63, 6'd9};
        rd_raw = 3'b001;
        #1;
        chk("dup_youngest", rd_data[0], 0);
        drain_en = 1'b1;
        repeat (2) cyc();
        chk("dup_raw1", rd_data[0], 1);
        rd_raw = 3'b000;
        #1;
        chk("dup_raw0", rd_data[0], 0);
        // three ports, same-cycle write not forwarded
        drain_en = 1'b0;
        put(6'd8, 1'b1);
        rd_addr = {6'd9, 6'd8, 6'd7};
        wr_valid = 1'b1; wr_addr = 6'd7; wr_data = 1'b1;
        #1;
        chk("fwd3_pre", rd_data, 3'b010);
        cyc();
        wr_valid = 1'b0;
        #1;
        chk("fwd3_post", rd_data, 3'b011);
        drain_en = 1'b1;
        repeat (2) cyc();
        chk("fwd3_drained", rd_data, 3'b000);
        // full queue with continuous push and drain, several wraps
        drain_en = 1'b0;
        for (int k = 0; k < 4; k++) put(6'(10 + k), k[0]);
        drain_en = 1'b1;
        wr_valid = 1'b1;
        for (int k = 0; k < 14; k++) begin
            wr_addr = 6'(20 + k);
            wr_data = ~k[0];
            cyc();
        end
        wr_valid = 1'b0;
        chk("wrap_occ", occupancy, 3);
        repeat (4) cyc();
        chk("wrap_idle", idle, 1);
        // reset mid-operation discards queue
        drain_en = 1'b0;
        for (int k = 0; k < 3; k++) put(6'(40 + k), 1'b1);
        drain_en = 1'b1;
        #1;
        chk("pre_rst_we", ram_we, 1);
        RST = 1'b1;
        #1;
        chk("async_rst_we", ram_we, 0);
        chk("async_rst_idle", idle, 1);
        chk("async_rst_occ", occupancy, 0);
        sb.delete();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (3) cyc();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
